alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequential initiator that drives the 16-bit combinational ALU (4-bit opcode, 16-bit A/B, 16-bit C, Cout overflow flag). It accepts tagged operation requests over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. After a fixed settle time it captures C and Cout, and returns them with the tag over a valid/ready response channel. It also keeps an accumulator for chained operations and a saturating signed-overflow counter for ADD/SUB.

Parameters:
TAG_W, 4, width of request/response tag
SETTLE, 1, cycles the ALU inputs are held before capture; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_a  input  16  operand A; ignored when req_chain=1
req_b  input  16  operand B
req_op  input  4  ALU opcode: 0000 ADD, 0001 SUB ... 1111 RL
req_chain  input  1  1 = use accumulator as operand A
req_tag  input  TAG_W  opaque tag echoed on response
alu_a  output  16  registered ALU operand A
alu_b  output  16  registered ALU operand B
alu_op  output  4  registered ALU opcode
alu_c  input  16  ALU result
alu_cout  input  1  ALU overflow flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_c  output  16  captured result
rsp_cout  output  1  captured overflow flag
rsp_tag  output  TAG_W  tag of the captured operation
acc  output  16  accumulator = last captured result
ovf_count  output  16  count of ADD/SUB captures with Cout=1, saturating
clr_stats  input  1  synchronous clear of ovf_count
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; req_ready=1; rsp_valid=0; alu_a, alu_b, alu_op, rsp_c, rsp_tag, acc and ovf_count all 0; rsp_cout=0; busy=0; settle counter=0. Reset mid-operation abandons the in-flight operation, and no response is produced for it.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: req_ready=1. On an edge where req_valid=1, the request is accepted. At that edge:
  - alu_a <= (req_chain ? acc : req_a);
  - alu_b <= req_b; alu_op <= req_op;
  - the internal tag register <= req_tag;
  - the settle counter is loaded with SETTLE-1;
  - state <= DRIVE.
- DRIVE: req_ready=0. While the counter is nonzero, decrement it each cycle. On the edge where the counter is 0:
  - rsp_c <= alu_c; rsp_cout <= alu_cout; rsp_tag <= the tag register; acc <= alu_c;
  - rsp_valid <= 1; state <= RESP.
- Latency: with acceptance at edge T, rsp_valid rises at edge T+SETTLE. For SETTLE=1, the response is visible the cycle after acceptance.
- RESP: req_ready=0. rsp_c, rsp_cout and rsp_tag stay stable while rsp_valid=1 and rsp_ready=0. On an edge with rsp_ready=1: rsp_valid <= 0 and state <= IDLE. The next request can be accepted one cycle later.
- alu_a, alu_b and alu_op change only on acceptance. They hold their last values in all other states.
- ovf_count:
  - On the capture edge, increment by 1 if the captured op is 0000 or 0001 and alu_cout=1. Hold at 16'hFFFF; no wrap.
  - clr_stats=1 sets it to 0 and takes priority over a same-edge increment.
  - Captures of other opcodes never change the count, even if alu_cout=1.
- acc updates for every opcode. A chained request reads the acc value from before the current capture.
- req_valid in a non-IDLE state is ignored, and the request is not accepted. The requester must hold it until req_ready=1.

Test Plan:
- With ALU instantiated, SETTLE=1: ADD a=0x7FFF b=0x0001 tag=3 -> rsp_valid exactly 1 cycle after acceptance; rsp_c=0x8000, rsp_cout=1, rsp_tag=3; ovf_count=1.
- SUB a=0x0005 b=0x0003 -> rsp_c=0x0002, rsp_cout=0, ovf_count unchanged. Then AND a=0xF0F0 b=0xFF00 -> rsp_c=0xF000.
- Chain: ADD 0x0010+0x0001 -> 0x0011, then chain=1 ADD b=0x0002 (req_a=0xDEAD) -> alu_a=0x0011, rsp_c=0x0013, acc=0x0013.
- Backpressure, SETTLE=3: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, req_ready=0, a second req_valid is not accepted. Release -> IDLE next cycle, then the second request is accepted.
- reset_n pulsed low while in DRIVE -> rsp_valid stays 0, acc=0, ovf_count=0, req_ready=1 immediately, and no stale response appears afterwards.
- Force ovf_count to 0xFFFE via 2 overflowing ADDs after preload: the next overflow gives 0xFFFF and a further one holds 0xFFFF. An overflow capture with clr_stats=1 on the same edge -> 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 16-bit ALU. It registers a tagged request onto the ALU inputs
// and waits SETTLE cycles. It then captures the result into a valid/ready response, an accumulator and an overflow counter.
`timescale 1ns/1ps
module alu_issue_ctrl #(
   parameter int TAG_W  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [15:0]      req_a,
   input  logic [15:0]      req_b,
   input  logic [3:0]       req_op,
   input  logic             req_chain,
   input  logic [TAG_W-1:0] req_tag,
   output logic [15:0]      alu_a,
   output logic [15:0]      alu_b,
   output logic [3:0]       alu_op,
   input  logic [15:0]      alu_c,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_c,
   output logic             rsp_cout,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [15:0]      acc,
   output logic [15:0]      ovf_count,
   input  logic             clr_stats,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_cnt;
   logic [15:0]      r_alu_a;
   logic [15:0]      r_alu_b;
   logic [3:0]       r_alu_op;
   logic [TAG_W-1:0] r_tag;
   logic [15:0]      r_rsp_c;
   logic             r_rsp_cout;
   logic [TAG_W-1:0] r_rsp_tag;
   logic [15:0]      r_acc;
   logic [15:0]      r_ovf_count;
   logic             w_accept;
   logic             w_capture;
   logic             w_ovf_hit;

   assign w_accept  = (r_state == S_IDLE) && req_valid;
   assign w_capture = (r_state == S_DRIVE) && (r_cnt == 4'd0);
   // Only signed ADD (0000) and SUB (0001) overflows are counted.
   assign w_ovf_hit = w_capture && alu_cout && (r_alu_op[3:1] == 3'b000);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // NOTE: the default assignment first keeps this combinational block from inferring a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (req_valid)      w_next_state = S_DRIVE;
         S_DRIVE: if (r_cnt == 4'd0)  w_next_state = S_RESP;
         S_RESP:  if (rsp_ready)      w_next_state = S_IDLE;
         default:                     w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (r_state == S_IDLE);
      rsp_valid = (r_state == S_RESP);
      busy      = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= 4'd0;
         r_alu_a    <= 16'd0;
         r_alu_b    <= 16'd0;
         r_alu_op   <= 4'd0;
         r_tag      <= '0;
         r_rsp_c    <= 16'd0;
         r_rsp_cout <= 1'b0;
         r_rsp_tag  <= '0;
         r_acc      <= 16'd0;
      end else begin
         if (w_accept) begin
            // Chained requests read the accumulator, which is stable while idle.
            r_alu_a  <= req_chain ? r_acc : req_a;
            r_alu_b  <= req_b;
            r_alu_op <= req_op;
            r_tag    <= req_tag;
            r_cnt    <= CNT_LOAD;
         end else if ((r_state == S_DRIVE) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_rsp_c    <= alu_c;
            r_rsp_cout <= alu_cout;
            r_rsp_tag  <= r_tag;
            r_acc      <= alu_c;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                               r_ovf_count <= 16'd0;
      else if (clr_stats)                         r_ovf_count <= 16'd0;
      else if (w_ovf_hit && (r_ovf_count != 16'hFFFF)) r_ovf_count <= r_ovf_count + 16'd1;
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign rsp_c     = r_rsp_c;
   assign rsp_cout  = r_rsp_cout;
   assign rsp_tag   = r_rsp_tag;
   assign acc       = r_acc;
   assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: instance 0 uses SETTLE=1 and instance 1 uses SETTLE=3, each wired to a behavioural stand-in ALU.
// The driver pushes expected responses when a request is accepted, and a negedge monitor pops them on each response handshake.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

   localparam int TAG_W = 4;

   typedef struct {
      logic [15:0]      c;
      logic             cout;
      logic [TAG_W-1:0] tag;
      logic [15:0]      ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n   [2];
   logic             req_valid [2];
   logic             req_ready [2];
   logic [15:0]      req_a     [2];
   logic [15:0]      req_b     [2];
   logic [3:0]       req_op    [2];
   logic             req_chain [2];
   logic [TAG_W-1:0] req_tag   [2];
   logic [15:0]      alu_a     [2];
   logic [15:0]      alu_b     [2];
   logic [3:0]       alu_op    [2];
   logic [15:0]      alu_c     [2];
   logic             alu_cout  [2];
   logic             rsp_valid [2];
   logic             rsp_ready [2];
   logic [15:0]      rsp_c     [2];
   logic             rsp_cout  [2];
   logic [TAG_W-1:0] rsp_tag   [2];
   logic [15:0]      acc       [2];
   logic [15:0]      ovf_count [2];
   logic             clr_stats [2];
   logic             busy      [2];

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [15:0] m_acc [2];
   logic [15:0] m_ovf [2];

   // Stand-in ALU: signed-overflow flag for ADD/SUB, rotate-out for RL, parity for the rest.
   function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
      logic [15:0] c;
      logic        v;
      case (op)
         4'd0:    begin c = a + b; v = (a[15] == b[15]) && (c[15] != a[15]); end
         4'd1:    begin c = a - b; v = (a[15] != b[15]) && (c[15] != a[15]); end
         4'd2:    begin c = a & b; v = ^c; end
         4'd3:    begin c = a | b; v = ^c; end
         4'd4:    begin c = a ^ b; v = ^c; end
         4'd15:   begin c = {a[14:0], a[15]}; v = a[15]; end
         default: begin c = a + {b[14:0], 1'b0}; v = ^c; end
      endcase
      return {v, c};
   endfunction

   assign {alu_cout[0], alu_c[0]} = alu_f(alu_a[0], alu_b[0], alu_op[0]);
   assign {alu_cout[1], alu_c[1]} = alu_f(alu_a[1], alu_b[1], alu_op[1]);

   alu_issue_ctrl #(.TAG_W(TAG_W), .SETTLE(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]), .req_chain(req_chain[0]),
      .req_tag(req_tag[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
      .alu_c(alu_c[0]), .alu_cout(alu_cout[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_c(rsp_c[0]), .rsp_cout(rsp_cout[0]), .rsp_tag(rsp_tag[0]), .acc(acc[0]),
      .ovf_count(ovf_count[0]), .clr_stats(clr_stats[0]), .busy(busy[0]));

   alu_issue_ctrl #(.TAG_W(TAG_W), .SETTLE(3)) u_dut1 (
      .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]), .req_chain(req_chain[1]),
      .req_tag(req_tag[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
      .alu_c(alu_c[1]), .alu_cout(alu_cout[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_c(rsp_c[1]), .rsp_cout(rsp_cout[1]), .rsp_tag(rsp_tag[1]), .acc(acc[1]),
      .ovf_count(ovf_count[1]), .clr_stats(clr_stats[1]), .busy(busy[1]));

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic bit pop_exp(input int k, output exp_t e);
      if (k == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1.pop_front();
      end
      return 1'b1;
   endfunction

   // Reference model: operand selection, result, accumulator and saturating counter from the rules.
   task automatic model_accept(input int k, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                               input bit chain, input logic [TAG_W-1:0] tag, input bit clr,
                               output logic [15:0] a_eff);
      exp_t        e;
      logic [16:0] r;
      a_eff = chain ? m_acc[k] : a;
      r = alu_f(a_eff, b, op);
      m_acc[k] = r[15:0];
      if (clr) m_ovf[k] = 16'd0;
      else if (op <= 4'd1 && r[16] && m_ovf[k] != 16'hFFFF) m_ovf[k] = m_ovf[k] + 16'd1;
      e.c = r[15:0]; e.cout = r[16]; e.tag = tag; e.ovf = m_ovf[k];
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Present a request and hold it until accepted; waits = negedges spent waiting for req_ready.
   task automatic send(input int k, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       input bit chain, input logic [TAG_W-1:0] tag, output int waits);
      logic [15:0] a_eff;
      req_a[k] = a; req_b[k] = b; req_op[k] = op; req_chain[k] = chain; req_tag[k] = tag;
      req_valid[k] = 1'b1;
      waits = 0;
      while (waits < 50) begin
         @(negedge clk);
         waits++;
         if (req_ready[k]) break;
      end
      if (!req_ready[k]) begin
         fail_now("req_ready timeout");
         req_valid[k] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      model_accept(k, a, b, op, chain, tag, clr_stats[k], a_eff);
      check("alu_a", alu_a[k], a_eff);
      check("alu_b", alu_b[k], b);
      check("alu_op", alu_op[k], op);
   endtask

   task automatic wait_rsp(input int k);
      int n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (rsp_valid[k]) break;
      end
      check("rsp latency", n, settle_of(k));
   endtask

   task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input bit chain, input logic [TAG_W-1:0] tag);
      int w;
      send(k, a, b, op, chain, tag, w);
      wait_rsp(k);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset_n[k] && rsp_valid[k] && rsp_ready[k]) begin
            exp_t e;
            if (!pop_exp(k, e)) begin
               fail_now("unexpected response");
            end else begin
               check("rsp_c", rsp_c[k], e.c);
               check("rsp_cout", rsp_cout[k], e.cout);
               check("rsp_tag", rsp_tag[k], e.tag);
               check("acc", acc[k], e.c);
               check("ovf_count", ovf_count[k], e.ovf);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      int          seen;
      logic [16:0] r;
      logic [15:0] a_first;
      for (int k = 0; k < 2; k++) begin
         reset_n[k] = 1'b0; req_valid[k] = 1'b0; req_a[k] = '0; req_b[k] = '0; req_op[k] = '0;
         req_chain[k] = 1'b0; req_tag[k] = '0; rsp_ready[k] = 1'b1; clr_stats[k] = 1'b0;
         m_acc[k] = 16'd0; m_ovf[k] = 16'd0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("reset req_ready", req_ready[k], 1);
         check("reset rsp_valid", rsp_valid[k], 0);
         check("reset busy", busy[k], 0);
         check("reset alu_a", alu_a[k], 0);
         check("reset alu_op", alu_op[k], 0);
         check("reset rsp_c", rsp_c[k], 0);
         check("reset rsp_tag", rsp_tag[k], 0);
         check("reset acc", acc[k], 0);
         check("reset ovf", ovf_count[k], 0);
         reset_n[k] = 1'b1;
      end
      @(posedge clk);
      #1;

      // Directed sequence on SETTLE=1
      issue(0, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 4'd3);
      issue(0, 16'h0005, 16'h0003, 4'd1, 1'b0, 4'd4);
      issue(0, 16'hF0F0, 16'hFF00, 4'd2, 1'b0, 4'd5);
      issue(0, 16'h0010, 16'h0001, 4'd0, 1'b0, 4'd6);
      issue(0, 16'hDEAD, 16'h0002, 4'd0, 1'b1, 4'd7);
      issue(0, 16'h0001, 16'h0000, 4'd4, 1'b0, 4'd8);
      issue(0, 16'h8001, 16'h0000, 4'd15, 1'b0, 4'd9);

      // Randomised traffic on both instances, biased toward ADD/SUB
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 30; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            issue(k, 16'($urandom), 16'($urandom), op, $urandom_range(0, 2) == 0, 4'($urandom));
         end
      end

      // Saturation and clear-priority on SETTLE=1
      force u_dut0.r_ovf_count = 16'hFFFC;
      @(posedge clk);
      #1;
      release u_dut0.r_ovf_count;
      m_ovf[0] = 16'hFFFC;
      check("ovf preload", ovf_count[0], 16'hFFFC);
      for (int i = 0; i < 4; i++) issue(0, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 4'(i));
      check("ovf saturated", ovf_count[0], 16'hFFFF);
      clr_stats[0] = 1'b1;
      issue(0, 16'h8000, 16'h0001, 4'd1, 1'b0, 4'd12);
      clr_stats[0] = 1'b0;
      check("ovf cleared", ovf_count[0], 0);

      // Backpressure on SETTLE=3
      rsp_ready[1] = 1'b0;
      send(1, 16'h1234, 16'h1111, 4'd0, 1'b0, 4'hA, w);
      a_first = 16'h1234;
      wait_rsp(1);
      r = alu_f(16'h1234, 16'h1111, 4'd0);
      req_a[1] = 16'h0100; req_b[1] = 16'h0200; req_op[1] = 4'd3; req_chain[1] = 1'b0;
      req_tag[1] = 4'hB; req_valid[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp rsp_valid", rsp_valid[1], 1);
         check("bp rsp_c", rsp_c[1], r[15:0]);
         check("bp rsp_tag", rsp_tag[1], 4'hA);
         check("bp req_ready", req_ready[1], 0);
         check("bp alu_a held", alu_a[1], a_first);
      end
      @(posedge clk);
      #1;
      rsp_ready[1] = 1'b1;
      send(1, 16'h0100, 16'h0200, 4'd3, 1'b0, 4'hB, w);
      check("bp accept delay", w, 2);
      wait_rsp(1);
      @(posedge clk);
      #1;

      // Reset while in DRIVE abandons the operation
      send(1, 16'h4444, 16'h5555, 4'd0, 1'b0, 4'hC, w);
      @(negedge clk);
      reset_n[1] = 1'b0;
      #1;
      check("mid-reset rsp_valid", rsp_valid[1], 0);
      check("mid-reset req_ready", req_ready[1], 1);
      check("mid-reset acc", acc[1], 0);
      check("mid-reset ovf", ovf_count[1], 0);
      check("mid-reset busy", busy[1], 0);
      q1.delete();
      m_acc[1] = 16'd0;
      m_ovf[1] = 16'd0;
      @(negedge clk);
      reset_n[1] = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) seen++;
      end
      check("no stale response", seen, 0);
      @(posedge clk);
      #1;
      issue(1, 16'hDEAD, 16'h0005, 4'd0, 1'b1, 4'hD);

      repeat (3) @(posedge clk);
      check("q0 drained", q0.size(), 0);
      check("q1 drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
